// File: rtl/seg_page_scheduler.sv
// Pages a latched multi-nibble hex value onto a two-digit 7-segment pair, two nibbles per page,
// starting at the most significant non-zero byte and wrapping back to it after page 0.
module seg_page_scheduler #(
    parameter int DIGITS       = 8,
    parameter int DWELL_CYCLES = 12_000_000,
    parameter int GAP_CYCLES   = 3_000_000,
    localparam int PAGES       = DIGITS / 2,
    localparam int PW          = (PAGES > 1) ? $clog2(PAGES) : 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  value_valid,
    output logic                  value_ready,
    output logic                  busy,
    output logic [PW-1:0]         page,
    output logic [6:0]            ss1_A_G,
    output logic [6:0]            ss2_A_G
);

    localparam int MAXC = (DWELL_CYCLES > GAP_CYCLES) ? DWELL_CYCLES : GAP_CYCLES;
    localparam int TW   = $clog2(MAXC + 1);
    localparam logic [TW-1:0] DWELL_LAST = TW'(DWELL_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LAST   = (GAP_CYCLES > 0) ? TW'(GAP_CYCLES - 1) : '0;
    localparam logic [6:0]    BLANK      = 7'h7F;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SHOW = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    // Handshake: a value is taken on a rising edge where value_valid and value_ready are both high.
    // value_ready is high in IDLE and GAP only; offers made while it is low are simply dropped.
    state_t                r_state;
    logic [4*DIGITS-1:0]   r_value;
    logic [PW-1:0]         r_top;
    logic [PW-1:0]         r_page;
    logic [TW-1:0]         r_timer;
    logic [6:0]            r_ss1;
    logic [6:0]            r_ss2;
    logic                  r_busy;
    logic                  r_ready;

    logic                  w_accept;
    logic [PW-1:0]         w_top_in;
    logic [PW-1:0]         w_next_page;
    logic                  w_dwell_end;
    logic                  w_gap_end;

    function automatic logic [6:0] enc(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    function automatic logic [3:0] nib(input logic [4*DIGITS-1:0] v, input logic [PW-1:0] pg,
                                       input logic hi);
        logic [4*DIGITS-1:0] sh;
        sh = v >> (8 * int'(pg) + 4 * int'(hi));
        return sh[3:0];
    endfunction

    // Highest page holding a non-zero byte; stays 0 for an all-zero value.
    always_comb begin
        w_top_in = '0;
        for (int p = 0; p < PAGES; p++) begin
            if (8'(value >> (8 * p)) != 8'h00) begin
                w_top_in = PW'(p);
            end
        end
    end

    assign w_accept    = value_valid & r_ready;
    assign w_next_page = (r_page == '0) ? r_top : (r_page - PW'(1));
    assign w_dwell_end = (r_timer == DWELL_LAST);
    assign w_gap_end   = (r_timer == GAP_LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_value <= '0;
            r_top   <= '0;
            r_page  <= '0;
            r_timer <= '0;
            r_ss1   <= BLANK;
            r_ss2   <= BLANK;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
        end else if (w_accept) begin
            r_state <= S_SHOW;
            r_value <= value;
            r_top   <= w_top_in;
            r_page  <= w_top_in;
            r_timer <= '0;
            r_ss1   <= enc(nib(value, w_top_in, 1'b1));
            r_ss2   <= enc(nib(value, w_top_in, 1'b0));
            r_busy  <= 1'b1;
            r_ready <= 1'b0;
        end else begin
            case (r_state)
                S_SHOW: begin
                    if (w_dwell_end) begin
                        r_timer <= '0;
                        if (GAP_CYCLES > 0) begin
                            r_state <= S_GAP;
                            r_ss1   <= BLANK;
                            r_ss2   <= BLANK;
                            r_ready <= 1'b1;
                        end else begin
                            r_page <= w_next_page;
                            r_ss1  <= enc(nib(r_value, w_next_page, 1'b1));
                            r_ss2  <= enc(nib(r_value, w_next_page, 1'b0));
                        end
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                S_GAP: begin
                    if (w_gap_end) begin
                        r_state <= S_SHOW;
                        r_timer <= '0;
                        r_page  <= w_next_page;
                        r_ss1   <= enc(nib(r_value, w_next_page, 1'b1));
                        r_ss2   <= enc(nib(r_value, w_next_page, 1'b0));
                        r_ready <= 1'b0;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign value_ready = r_ready;
    assign busy        = r_busy;
    assign page        = r_page;
    assign ss1_A_G     = r_ss1;
    assign ss2_A_G     = r_ss2;

endmodule

// File: tb/tb_seg_page_scheduler.sv
// Bench for seg_page_scheduler: a paging-schedule model predicts every cycle's display state.
module tb_seg_page_scheduler;

    localparam int DIGITS = 8;
    localparam int DWELL  = 4;
    localparam int GAP    = 2;
    localparam int W      = 18;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] value = '0;
    logic        value_valid = 1'b0;
    logic        value_ready;
    logic        busy;
    logic [1:0]  page;
    logic [6:0]  ss1_A_G;
    logic [6:0]  ss2_A_G;

    logic [31:0] value2 = '0;
    logic        value_valid2 = 1'b0;
    logic        value_ready2;
    logic        busy2;
    logic [1:0]  page2;
    logic [6:0]  ss1_2;
    logic [6:0]  ss2_2;

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_q[$];

    logic [6:0] SEG [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                             7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                             7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                             7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    localparam logic [W-1:0] IDLE_EXP = {1'b1, 1'b0, 2'd0, 7'h7F, 7'h7F};

    always #5 clock = ~clock;

    seg_page_scheduler #(.DIGITS(DIGITS), .DWELL_CYCLES(DWELL), .GAP_CYCLES(GAP)) dut (
        .clock(clock), .reset_n(reset_n), .value(value), .value_valid(value_valid),
        .value_ready(value_ready), .busy(busy), .page(page),
        .ss1_A_G(ss1_A_G), .ss2_A_G(ss2_A_G));

    seg_page_scheduler #(.DIGITS(DIGITS), .DWELL_CYCLES(DWELL), .GAP_CYCLES(0)) dut_nogap (
        .clock(clock), .reset_n(reset_n), .value(value2), .value_valid(value_valid2),
        .value_ready(value_ready2), .busy(busy2), .page(page2),
        .ss1_A_G(ss1_2), .ss2_A_G(ss2_2));

    // Cycle k after an accept: pages run top..0 then wrap, each shown DWELL cycles then blank gap cycles.
    function automatic logic [W-1:0] model(input logic [31:0] v, input int k, input int gap);
        int top;
        int per;
        int pg;
        logic in_gap;
        logic [6:0] s1;
        logic [6:0] s2;
        logic [1:0] pg2;
        top = 0;
        for (int p = 0; p < 4; p++) begin
            if (((v >> (8 * p)) & 32'hFF) != 0) top = p;
        end
        per    = DWELL + gap;
        pg     = top - ((k / per) % (top + 1));
        in_gap = (k % per) >= DWELL;
        s1 = in_gap ? 7'h7F : SEG[(v >> (8 * pg + 4)) & 32'hF];
        s2 = in_gap ? 7'h7F : SEG[(v >> (8 * pg)) & 32'hF];
        pg2 = 2'(pg);
        return {in_gap, 1'b1, pg2, s1, s2};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Offers v and waits (bounded) for the scheduler to be ready; returns after the accepting edge.
    task automatic offer(input logic [31:0] v, output bit ok);
        value = v;
        value_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (value_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        tick();
        value_valid = 1'b0;
    endtask

    task automatic check_sched(input string name, input logic [31:0] v, input int ncyc);
        logic [W-1:0] e;
        logic [W-1:0] o;
        for (int k = 0; k < ncyc; k++) exp_q.push_back(model(v, k, GAP));
        for (int k = 0; k < ncyc; k++) begin
            e = exp_q.pop_front();
            o = {value_ready, busy, page, ss1_A_G, ss2_A_G};
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL %s cyc %0d value %h: got %h expected %h", name, k, v, o, e);
            end
            tick();
        end
    endtask

    task automatic accept_and_check(input string name, input logic [31:0] v, input int ncyc);
        bit ok;
        offer(v, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s_accept_timeout: got ready=0 expected ready=1 within 20 cycles", name);
        end
        check_sched(name, v, ncyc);
    endtask

    task automatic test_reset();
        logic [W-1:0] o;
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            o = {value_ready, busy, page, ss1_A_G, ss2_A_G};
            n_checks++;
            if (o !== IDLE_EXP) begin
                n_fail++;
                $display("FAIL reset_hold cyc %0d: got %h expected %h", i, o, IDLE_EXP);
            end
        end
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            o = {value_ready, busy, page, ss1_A_G, ss2_A_G};
            n_checks++;
            if (o !== IDLE_EXP) begin
                n_fail++;
                $display("FAIL idle_hold cyc %0d: got %h expected %h", i, o, IDLE_EXP);
            end
        end
    endtask

    task automatic test_basic();
        accept_and_check("basic_1234", 32'h0000_1234, 26);
    endtask

    task automatic test_zero();
        accept_and_check("zero_value", 32'h0000_0000, 14);
    endtask

    task automatic test_top_page();
        accept_and_check("top3_AB", 32'hAB00_0000, 32);
    endtask

    task automatic test_backpressure();
        logic [W-1:0] e;
        logic [W-1:0] o;
        bit ok;
        offer(32'h0000_1234, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL bp_accept_timeout: got ready=0 expected ready=1 within 20 cycles");
        end
        value = 32'h0000_0056;
        value_valid = 1'b1;
        for (int k = 0; k <= DWELL; k++) begin
            e = model(32'h0000_1234, k, GAP);
            o = {value_ready, busy, page, ss1_A_G, ss2_A_G};
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL bp_hold cyc %0d: got %h expected %h", k, o, e);
            end
            tick();
        end
        value_valid = 1'b0;
        check_sched("bp_gap_accept_56", 32'h0000_0056, 14);
    endtask

    task automatic test_async_reset();
        logic [W-1:0] o;
        accept_and_check("pre_async", 32'h0000_9876, 2);
        #2;
        reset_n = 1'b0;
        #1;
        o = {value_ready, busy, page, ss1_A_G, ss2_A_G};
        n_checks++;
        if (o !== IDLE_EXP) begin
            n_fail++;
            $display("FAIL async_reset_immediate: got %h expected %h", o, IDLE_EXP);
        end
        tick();
        reset_n = 1'b1;
        tick();
        o = {value_ready, busy, page, ss1_A_G, ss2_A_G};
        n_checks++;
        if (o !== IDLE_EXP) begin
            n_fail++;
            $display("FAIL async_reset_after: got %h expected %h", o, IDLE_EXP);
        end
    endtask

    task automatic test_no_gap();
        logic [W-1:0] e;
        logic [W-1:0] o;
        value2 = 32'h0000_1234;
        value_valid2 = 1'b1;
        n_checks++;
        if (value_ready2 !== 1'b1) begin
            n_fail++;
            $display("FAIL nogap_ready_idle: got %b expected 1", value_ready2);
        end
        tick();
        value_valid2 = 1'b0;
        for (int k = 0; k < 18; k++) exp_q.push_back(model(32'h0000_1234, k, 0));
        for (int k = 0; k < 18; k++) begin
            e = exp_q.pop_front();
            o = {value_ready2, busy2, page2, ss1_2, ss2_2};
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL nogap_1234 cyc %0d: got %h expected %h", k, o, e);
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic [31:0] v;
        for (int n = 0; n < 8; n++) begin
            v = $urandom;
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 1) == 1) v = v & ~(32'hFF << (8 * b));
            end
            accept_and_check("random", v, $urandom_range(8, 30));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_top_page();
        test_backpressure();
        test_random();
        test_async_reset();
        test_no_gap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
